// File: rtl/cordic_stream_ctrl.sv
// Stream controller around the CORDIC cosine pipeline.
// Credit-based issue, valid delay line and a FWFT result FIFO.
module cordic_stream_ctrl #(
    parameter int LATENCY = 35,
    parameter int DEPTH   = 64,
    parameter int AW      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_theta,
    input  logic [5:0]  cfg_n,
    output logic [31:0] cordic_theta,
    output logic [5:0]  cordic_n,
    input  logic [31:0] cordic_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);
    localparam logic [AW:0]   ONE     = (AW + 1)'(1);

    logic [LATENCY-1:0] vld_sr;
    logic [AW:0]        inflight;
    logic [AW:0]        fifo_count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [31:0]        mem [DEPTH];
    logic [AW+1:0]      credit_sum;
    logic               accept;
    logic               push;
    logic               pop;

    // Space is reserved for every issued angle, so a capture always fits.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready   = !reset && (credit_sum < DEPTH_W);
    assign accept     = in_valid && in_ready;
    assign push       = vld_sr[LATENCY-1];
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign busy       = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr       <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cordic_theta <= '0;
            cordic_n     <= 6'd32;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], accept};
            if (accept) begin
                cordic_theta <= in_theta;
            end
            // Iteration count only moves while the pipeline is empty.
            if (!busy && !accept) begin
                cordic_n <= cfg_n;
            end
            unique case ({accept, push})
                2'b10:   inflight <= inflight + ONE;
                2'b01:   inflight <= inflight - ONE;
                default: inflight <= inflight;
            endcase
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE;
                2'b01:   fifo_count <= fifo_count - ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= cordic_result;
        end
    end

    overflow_a : assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count == (AW + 1)'(DEPTH))));

endmodule

// File: tb/tb_cordic_stream_ctrl.sv
// Bench for cordic_stream_ctrl with a behavioural pipeline stand-in
// and a queue-based reference model checked every cycle.
module tb_cordic_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_theta;
    logic [5:0]  cfg_n;
    logic [31:0] cordic_theta;
    logic [5:0]  cordic_n;
    logic [31:0] cordic_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_stream_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_theta     (in_theta),
        .cfg_n        (cfg_n),
        .cordic_theta (cordic_theta),
        .cordic_n     (cordic_n),
        .cordic_result(cordic_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    // Stand-in for the 34-register pipeline: a keyed transform of (theta, n).
    function automatic logic [31:0] pipe_f(input logic [31:0] th,
                                           input logic [5:0] n);
        return th ^ {n, n, n, n, n, 2'b00} ^ 32'h5A5A0000;
    endfunction

    logic [31:0] pth [34];
    logic [5:0]  pn  [34];

    initial begin
        for (int i = 0; i < 34; i++) begin
            pth[i] = '0;
            pn[i]  = '0;
        end
    end

    always @(posedge clk) begin
        pth[0] <= cordic_theta;
        pn[0]  <= cordic_n;
        for (int i = 1; i < 34; i++) begin
            pth[i] <= pth[i-1];
            pn[i]  <= pn[i-1];
        end
    end

    assign cordic_result = pipe_f(pth[33], pn[33]);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: results sit in flight for 35 edges, then in a FIFO.
    typedef struct {
        logic [31:0] d;
        int          t;
    } fl_t;

    fl_t         infl [$];
    logic [31:0] fq   [$];
    logic [5:0]  m_n     = 6'd32;
    logic [31:0] m_theta = '0;
    int          cyc     = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          max_fq  = 0;

    always @(posedge clk) begin
        bit acc;
        bit pop;
        bit bz;
        bz = (infl.size() != 0) || (fq.size() != 0);
        if (reset) begin
            infl.delete();
            fq.delete();
            m_n     = 6'd32;
            m_theta = '0;
        end else begin
            acc = in_valid && ((infl.size() + fq.size()) < 64);
            pop = (fq.size() != 0) && out_ready;
            if (pop) begin
                void'(fq.pop_front());
                pop_cnt++;
            end
            if (infl.size() != 0 && infl[0].t == cyc) begin
                fq.push_back(infl[0].d);
                void'(infl.pop_front());
            end
            if (acc) begin
                infl.push_back('{pipe_f(in_theta, m_n), cyc + 35});
                m_theta = in_theta;
                acc_cnt++;
            end
            if (!bz && !acc) m_n = cfg_n;
            if (fq.size() > max_fq) max_fq = fq.size();
        end
        cyc++;
        #1;
        chk("in_ready", in_ready,
            !reset && ((infl.size() + fq.size()) < 64));
        chk("out_valid", out_valid, fq.size() != 0);
        chk("busy", busy, (infl.size() + fq.size()) != 0);
        chk("cordic_n", cordic_n, m_n);
        chk("cordic_theta", cordic_theta, m_theta);
        chk("out_data", out_data, (fq.size() != 0) ? fq[0] : 32'h0);
    end

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("drain", busy, 1'b0);
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < max);
    endtask

    initial begin
        int lat;
        int a0;
        int p0;
        int drops;
        int stale;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_theta  = '0;
        cfg_n     = 6'd32;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_cordic_n", cordic_n, 6'd32);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);

        // Single angle latency and value.
        in_theta = 32'h3F000000;
        in_valid = 1'b1;
        wait_valid(100, lat);
        chk("latency", lat, 36);
        chk("single_data", out_data, 32'hE7522080);
        wait_idle(50);

        // Back-to-back burst with a free-running consumer.
        a0 = acc_cnt;
        p0 = pop_cnt;
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_theta = $urandom;
            @(negedge clk);
            if (!in_ready) drops++;
        end
        in_valid = 1'b0;
        chk("burst_drops", drops, 0);
        chk("burst_accepts", acc_cnt - a0, 100);
        wait_idle(200);
        chk("burst_pops", pop_cnt - p0, 100);

        // Backpressure fills exactly DEPTH entries.
        a0 = acc_cnt;
        p0 = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 120; i++) begin
            in_valid = 1'b1;
            in_theta = $urandom;
            @(negedge clk);
        end
        chk("bp_accepts", acc_cnt - a0, 64);
        chk("bp_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) begin
            in_theta = $urandom;
            @(negedge clk);
        end
        chk("bp_one_more", acc_cnt - a0, 65);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);
        chk("bp_pops", pop_cnt - p0, 65);

        // Iteration count is frozen while busy.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_theta = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        cfg_n = 6'd8;
        repeat (5) @(negedge clk);
        chk("n_frozen", cordic_n, 6'd32);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("n_loaded", cordic_n, 6'd8);
        in_theta = 32'h3F800000;
        in_valid = 1'b1;
        wait_valid(100, lat);
        chk("n8_data", out_data, 32'h45580820);
        wait_idle(50);

        // Reset in the middle of a burst.
        cfg_n = 6'd32;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_theta  = $urandom;
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        stale = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        out_ready = 1'b1;
        in_theta  = 32'h3F000000;
        in_valid  = 1'b1;
        wait_valid(100, lat);
        chk("after_rst_data", out_data, 32'hE7522080);
        wait_idle(50);

        // Sparse input with a toggling consumer: push/pop at one entry.
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 120; i++) begin
            in_valid  = 1'($urandom);
            in_theta  = $urandom;
            out_ready = i[0];
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);
        chk("toggle_balance", pop_cnt - p0, acc_cnt - a0);
        chk("fifo_max_ok", max_fq <= 64, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
